// File: rtl/hazard_pkg.sv
// Shared types and helpers for the dual-issue scoreboard.
//   REG_W   : default register index width
//   NO_REG  : all-ones "no register" sentinel for a given index width
//   state_t : issue FSM states
//   instr_t : destination / source register triple of one instruction
package hazard_pkg;

    localparam int REG_W = 4;

    function automatic logic [31:0] NO_REG(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    typedef enum logic {
        PAIR   = 1'b0,
        B_ONLY = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] des;
        logic [REG_W-1:0] s1;
        logic [REG_W-1:0] s2;
    } instr_t;

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational intra-pair hazard detect between an older instruction A and
// a younger instruction B. The NO_REG sentinel never matches anything.
//   a_des/a_s1/a_s2 : older instruction registers
//   b_des/b_s1/b_s2 : younger instruction registers
//   hazard          : B reads A's dest (RAW), writes an A source (WAR),
//                     or writes A's dest (WAW)
module pair_hazard_check
    import hazard_pkg::*;
#(
    parameter int REG_W = hazard_pkg::REG_W
) (
    input  logic [REG_W-1:0] a_des,
    input  logic [REG_W-1:0] a_s1,
    input  logic [REG_W-1:0] a_s2,
    input  logic [REG_W-1:0] b_des,
    input  logic [REG_W-1:0] b_s1,
    input  logic [REG_W-1:0] b_s2,
    output logic             hazard
);

    localparam logic [REG_W-1:0] NOREG = REG_W'(NO_REG(REG_W));

    // Equality with one side checked against NO_REG is enough: a match
    // where both sides are NO_REG is suppressed by that same check.
    function automatic logic hit(input logic [REG_W-1:0] x, input logic [REG_W-1:0] y);
        return (x != NOREG) && (x == y);
    endfunction

    logic raw, war, waw;

    assign raw    = hit(a_des, b_s1) | hit(a_des, b_s2);
    assign war    = hit(b_des, a_s1) | hit(b_des, a_s2);
    assign waw    = hit(b_des, a_des);
    assign hazard = raw | war | waw;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue scoreboard between issue queue and execute stage.
// Checks an ordered pair (A older, B younger) against the register busy
// scoreboard and against each other, then issues both, A only (B on a later
// cycle from B_ONLY), or stalls. Issued instructions land in a registered
// output slot with valid/ready handshake.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : pair handshake; in_ready = whole pair consumed
//   a_*, b_valid, b_*   : instruction pair fields
//   out_ready           : execute stage accepts the output slot
//   iss_*               : registered output slot
//   wb_valid / wb_des   : writeback ports clearing busy bits
//   stall_cnt           : saturating count of in_valid && !in_ready cycles
module dual_issue_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_W  = hazard_pkg::REG_W,
    parameter int NUM_WB = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_W-1:0]        a_des,
    input  logic [REG_W-1:0]        a_s1,
    input  logic [REG_W-1:0]        a_s2,
    input  logic                    b_valid,
    input  logic [REG_W-1:0]        b_des,
    input  logic [REG_W-1:0]        b_s1,
    input  logic [REG_W-1:0]        b_s2,
    input  logic                    out_ready,
    output logic                    iss_a_valid,
    output logic                    iss_b_valid,
    output logic [REG_W-1:0]        iss_a_des,
    output logic [REG_W-1:0]        iss_a_s1,
    output logic [REG_W-1:0]        iss_a_s2,
    output logic [REG_W-1:0]        iss_b_des,
    output logic [REG_W-1:0]        iss_b_s1,
    output logic [REG_W-1:0]        iss_b_s2,
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*REG_W-1:0] wb_des,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int               NREG  = 1 << REG_W;
    localparam logic [REG_W-1:0] NOREG = REG_W'(NO_REG(REG_W));

    state_t            state_q, state_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              a_ok, b_ok, intra, slot_free;
    logic              iss_a, iss_b;

    // busy_q[NOREG] is held at 0, so plain indexing already ignores NO_REG.
    assign a_ok      = !busy_q[a_s1] && !busy_q[a_s2] && !busy_q[a_des];
    assign b_ok      = !busy_q[b_s1] && !busy_q[b_s2] && !busy_q[b_des];
    assign slot_free = !(iss_a_valid || iss_b_valid) || out_ready;

    pair_hazard_check #(.REG_W(REG_W)) u_hz (
        .a_des  (a_des),
        .a_s1   (a_s1),
        .a_s2   (a_s2),
        .b_des  (b_des),
        .b_s1   (b_s1),
        .b_s2   (b_s2),
        .hazard (intra)
    );

    always_comb begin
        iss_a    = 1'b0;
        iss_b    = 1'b0;
        in_ready = 1'b0;
        state_d  = state_q;
        case (state_q)
            PAIR: begin
                if (in_valid && a_ok && slot_free) begin
                    iss_a = 1'b1;
                    if (!b_valid || (b_ok && !intra)) begin
                        iss_b    = b_valid;
                        in_ready = 1'b1;
                    end else begin
                        // A goes now; B waits with A's dest visible in busy.
                        state_d = B_ONLY;
                    end
                end
            end
            B_ONLY: begin
                if (in_valid && b_ok && slot_free) begin
                    iss_b    = 1'b1;
                    in_ready = 1'b1;
                    state_d  = PAIR;
                end
            end
            default: state_d = PAIR;
        endcase
    end

    // Clears first, then sets, so a set wins on the same bit.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid[k]) busy_d[wb_des[k*REG_W +: REG_W]] = 1'b0;
        end
        if (iss_a) busy_d[a_des] = 1'b1;
        if (iss_b) busy_d[b_des] = 1'b1;
        busy_d[NOREG] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PAIR;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Slot reloads whenever it is free; a no-issue cycle writes zero valids.
    // Fields are captured unconditionally and only meaningful under valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_a_valid <= 1'b0;
            iss_b_valid <= 1'b0;
            iss_a_des   <= '0;
            iss_a_s1    <= '0;
            iss_a_s2    <= '0;
            iss_b_des   <= '0;
            iss_b_s1    <= '0;
            iss_b_s2    <= '0;
        end else if (slot_free) begin
            iss_a_valid <= iss_a;
            iss_b_valid <= iss_b;
            iss_a_des   <= a_des;
            iss_a_s1    <= a_s1;
            iss_a_s2    <= a_s2;
            iss_b_des   <= b_des;
            iss_b_s1    <= b_s1;
            iss_b_s2    <= b_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed test-plan steps followed by a constrained-random phase, all
// checked against a set-based reference model of the issue rules.
module tb_dual_issue_scoreboard;
    import hazard_pkg::*;

    localparam int REG_W  = 4;
    localparam int NUM_WB = 2;
    localparam int CNT_W  = 16;
    localparam int NR     = 16;
    localparam int NOR    = 15;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    in_valid = 1'b0, in_ready;
    logic [REG_W-1:0]        a_des = '0, a_s1 = '0, a_s2 = '0;
    logic                    b_valid = 1'b0;
    logic [REG_W-1:0]        b_des = '0, b_s1 = '0, b_s2 = '0;
    logic                    out_ready = 1'b1;
    logic                    iss_a_valid, iss_b_valid;
    logic [REG_W-1:0]        iss_a_des, iss_a_s1, iss_a_s2;
    logic [REG_W-1:0]        iss_b_des, iss_b_s1, iss_b_s2;
    logic [NUM_WB-1:0]       wb_valid = '0;
    logic [NUM_WB*REG_W-1:0] wb_des = '0;
    logic [CNT_W-1:0]        stall_cnt;

    always #5 clk = ~clk;

    dual_issue_scoreboard #(.REG_W(REG_W), .NUM_WB(NUM_WB), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_des(a_des), .a_s1(a_s1), .a_s2(a_s2),
        .b_valid(b_valid), .b_des(b_des), .b_s1(b_s1), .b_s2(b_s2),
        .out_ready(out_ready),
        .iss_a_valid(iss_a_valid), .iss_b_valid(iss_b_valid),
        .iss_a_des(iss_a_des), .iss_a_s1(iss_a_s1), .iss_a_s2(iss_a_s2),
        .iss_b_des(iss_b_des), .iss_b_s1(iss_b_s1), .iss_b_s2(iss_b_s2),
        .wb_valid(wb_valid), .wb_des(wb_des),
        .stall_cnt(stall_cnt)
    );

    // Reference model state
    bit     mbusy [NR];
    bit     mhold;          // A already gone, B still owed
    bit     mav, mbv;
    instr_t mia, mib;
    int     mstall;
    bit     mlast_rdy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit blk(int r);
        return (r != NOR) && mbusy[r];
    endfunction

    function automatic bit same(int x, int y);
        return (x != NOR) && (x == y);
    endfunction

    task automatic model_reset();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        mhold = 0; mav = 0; mbv = 0; mstall = 0; mlast_rdy = 0;
        mia = '0; mib = '0;
    endtask

    task automatic set_pair(input int ad, input int as1, input int as2,
                            input bit bv, input int bd, input int bs1, input int bs2);
        a_des = REG_W'(ad); a_s1 = REG_W'(as1); a_s2 = REG_W'(as2);
        b_valid = bv; b_des = REG_W'(bd); b_s1 = REG_W'(bs1); b_s2 = REG_W'(bs2);
    endtask

    task automatic set_wb(input bit v0, input int d0, input bit v1, input int d1);
        wb_valid = {v1, v0};
        wb_des   = {REG_W'(d1), REG_W'(d0)};
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic cycle(input string tag);
        bit a_ok, b_ok, hz, free, ia, ib, rdy, nh;
        logic [NR-1:0] mb;
        #1;
        a_ok = !blk(a_s1) && !blk(a_s2) && !blk(a_des);
        b_ok = !blk(b_s1) && !blk(b_s2) && !blk(b_des);
        free = !(mav || mbv) || out_ready;
        ia = 0; ib = 0; rdy = 0; nh = mhold;
        if (in_valid && free) begin
            if (!mhold) begin
                if (a_ok) begin
                    ia = 1;
                    hz = b_valid && (!b_ok || same(a_des, b_s1) || same(a_des, b_s2) ||
                                     same(b_des, a_s1) || same(b_des, a_s2) || same(b_des, a_des));
                    if (hz) nh = 1;
                    else begin ib = b_valid; rdy = 1; end
                end
            end else if (b_ok) begin
                ib = 1; rdy = 1; nh = 0;
            end
        end
        chk({tag, "_in_ready"}, in_ready, rdy);
        @(posedge clk);
        for (int k = 0; k < NUM_WB; k++)
            if (wb_valid[k]) mbusy[wb_des[k*REG_W +: REG_W]] = 0;
        if (ia && a_des != NOR) mbusy[a_des] = 1;
        if (ib && b_des != NOR) mbusy[b_des] = 1;
        if (free) begin
            mav = ia; mbv = ib;
            mia = '{des: a_des, s1: a_s1, s2: a_s2};
            mib = '{des: b_des, s1: b_s1, s2: b_s2};
        end
        if (in_valid && !rdy && mstall != (1 << CNT_W) - 1) mstall++;
        mhold = nh;
        mlast_rdy = rdy;
        #1;
        for (int i = 0; i < NR; i++) mb[i] = mbusy[i];
        chk({tag, "_a_valid"}, iss_a_valid, mav);
        chk({tag, "_b_valid"}, iss_b_valid, mbv);
        if (mav) chk({tag, "_a_fields"}, {iss_a_des, iss_a_s1, iss_a_s2}, mia);
        if (mbv) chk({tag, "_b_fields"}, {iss_b_des, iss_b_s1, iss_b_s2}, mib);
        chk({tag, "_stall"}, stall_cnt, mstall);
        chk({tag, "_busy"}, dut.busy_q, mb);
        chk({tag, "_state"}, dut.state_q, mhold ? B_ONLY : PAIR);
    endtask

    function automatic int rr();
        int v = $urandom_range(0, 6);
        return (v == 6) ? NOR : v;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_valid", iss_a_valid, 0);
        chk("rst_b_valid", iss_b_valid, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_busy", dut.busy_q, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean pair issues together
        in_valid = 1; out_ready = 1;
        set_pair(1, 2, 3, 1, 4, 5, 6);
        cycle("pair");
        chk("pair_busy1", dut.busy_q[1], 1);
        chk("pair_busy4", dut.busy_q[4], 1);
        in_valid = 0; set_wb(1, 1, 1, 4);
        cycle("clr1");
        set_wb(0, 0, 0, 0);

        // Intra RAW: A alone, B waits on busy[2] until writeback
        in_valid = 1;
        set_pair(2, 0, 1, 1, 3, 2, 5);
        cycle("raw_a");
        chk("raw_state", dut.state_q, B_ONLY);
        repeat (3) cycle("raw_hold");
        set_wb(1, 2, 0, 0);
        cycle("raw_wb");
        set_wb(0, 0, 0, 0);
        cycle("raw_b");
        chk("raw_b_issued", iss_b_valid, 1);
        chk("raw_stall_total", stall_cnt, 5);
        in_valid = 0; set_wb(1, 2, 1, 3);
        cycle("clr2");
        set_wb(0, 0, 0, 0);

        // Intra WAR: A alone, B next cycle without writeback
        in_valid = 1;
        set_pair(7, 4, 8, 1, 8, 1, 2);
        cycle("war_a");
        cycle("war_b");
        chk("war_b_des", iss_b_des, 8);
        in_valid = 0; set_wb(1, 7, 1, 8);
        cycle("clr3");
        set_wb(0, 0, 0, 0);

        // NO_REG everywhere: both issue, nothing becomes busy
        in_valid = 1;
        set_pair(15, 15, 15, 1, 15, 1, 2);
        cycle("noreg");
        chk("noreg_busy", dut.busy_q, 0);

        // Backpressure: slot held, pair waits
        out_ready = 0;
        set_pair(9, 10, 11, 1, 12, 13, 14);
        cycle("bp1");
        cycle("bp2");
        chk("bp_slot_held", iss_a_des, 15);
        out_ready = 1;
        cycle("bp_rel");
        chk("bp_rel_a_des", iss_a_des, 9);

        // Reset asynchronously while in B_ONLY with busy bits set
        set_pair(1, 2, 3, 1, 5, 1, 6);
        cycle("pre_rst");
        #2 rst_n = 0;
        #1;
        chk("arst_state", dut.state_q, PAIR);
        chk("arst_a_valid", iss_a_valid, 0);
        chk("arst_b_valid", iss_b_valid, 0);
        chk("arst_busy", dut.busy_q, 0);
        chk("arst_stall", stall_cnt, 0);
        model_reset();
        in_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Random phase; pair fields held while the pair is pending
        for (int n = 0; n < 400; n++) begin
            if (!(in_valid && !mlast_rdy)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                set_pair(rr(), rr(), rr(), ($urandom_range(0, 4) != 0), rr(), rr(), rr());
            end
            out_ready = ($urandom_range(0, 3) != 0);
            set_wb($urandom_range(0, 1) == 1, rr(), $urandom_range(0, 1) == 1, rr());
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
